// File: rtl/prog_mem_arbiter.sv
// Program-memory arbiter: CPU fetch (fixed priority) vs. loader port, with
// starvation relief for the loader and a RUN/DRAIN/LOAD ownership FSM.
module prog_mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 18,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CPU_REQ,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    output logic              CPU_GNT,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_HALTED,
    input  logic              LD_REQ,
    input  logic              LD_WE,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [DATA_W-1:0] LD_WDATA,
    output logic              LD_GNT,
    output logic              LD_RVALID,
    output logic [DATA_W-1:0] LD_RDATA,
    input  logic              LOAD_MODE_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [3:0] starv_q, starv_d;
    logic       force_ld;
    logic       cpu_gnt;
    logic       ld_gnt;

    // Grants and next state. Grants are suppressed while reset is held so a
    // write presented in the reset cycle never reaches the array.
    always_comb begin
        state_d  = state_q;
        cpu_gnt  = 1'b0;
        ld_gnt   = 1'b0;
        force_ld = 1'b0;
        case (state_q)
            ST_RUN: begin
                force_ld = LD_REQ && (starv_q == WAIT_LIM);
                cpu_gnt  = CPU_REQ && !force_ld;
                ld_gnt   = LD_REQ && !cpu_gnt;
                if (LOAD_MODE_REQ) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                ld_gnt  = LD_REQ;
                state_d = LOAD_MODE_REQ ? ST_LOAD : ST_RUN;
            end
            ST_LOAD: begin
                ld_gnt = LD_REQ;
                if (!LOAD_MODE_REQ) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (!RST) begin
            cpu_gnt = 1'b0;
            ld_gnt  = 1'b0;
        end
    end

    always_comb begin
        starv_d = 4'd0;
        if (state_q == ST_RUN && LD_REQ && !ld_gnt) begin
            starv_d = (starv_q == WAIT_LIM) ? starv_q : starv_q + 4'd1;
        end
    end

    // Tag of whoever owns the read data returning next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_gnt)                owner_d = OWN_CPU;
        else if (ld_gnt && !LD_WE)  owner_d = OWN_LD;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_RUN;
            owner_q <= OWN_NONE;
            starv_q <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            starv_q <= starv_d;
        end
    end

    assign CPU_GNT    = cpu_gnt;
    assign LD_GNT     = ld_gnt;
    assign CPU_HALTED = (state_q == ST_LOAD);
    assign CPU_RVALID = (owner_q == OWN_CPU);
    assign LD_RVALID  = (owner_q == OWN_LD);
    assign CPU_RDATA  = MEM_RDATA;
    assign LD_RDATA   = MEM_RDATA;
    assign MEM_ADDR   = ld_gnt ? LD_ADDR : CPU_ADDR;
    assign MEM_WE     = ld_gnt && LD_WE;
    assign MEM_WDATA  = LD_WDATA;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model with a shadow memory.
module tb_prog_mem_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 18;
  localparam int MAX_WAIT = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          CPU_REQ = 1'b0;
  logic [AW-1:0] CPU_ADDR = '0;
  logic          CPU_GNT;
  logic          CPU_RVALID;
  logic [DW-1:0] CPU_RDATA;
  logic          CPU_HALTED;
  logic          LD_REQ = 1'b0;
  logic          LD_WE = 1'b0;
  logic [AW-1:0] LD_ADDR = '0;
  logic [DW-1:0] LD_WDATA = '0;
  logic          LD_GNT;
  logic          LD_RVALID;
  logic [DW-1:0] LD_RDATA;
  logic          LOAD_MODE_REQ = 1'b0;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_WE;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  prog_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_GNT(CPU_GNT),
    .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA), .CPU_HALTED(CPU_HALTED),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_GNT(LD_GNT), .LD_RVALID(LD_RVALID), .LD_RDATA(LD_RDATA),
    .LOAD_MODE_REQ(LOAD_MODE_REQ),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA)
  );

  // ---------------- clock ----------------
  initial begin : clk_gen
    forever #5 CLK = ~CLK;
  end

  // ---------------- memory array (driven only by the DUT bus) ----------------
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] sh  [1024];
  logic [DW-1:0] mem_rd = '0;
  logic          img_load = 1'b1;

  always @(posedge CLK) begin
    if (img_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= sh[i];
    end else begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
      mem_rd <= mem[MEM_ADDR];
    end
  end
  assign MEM_RDATA = mem_rd;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = run, 1 = drain, 2 = load. Reads are queued at grant with
  // their owner (1 cpu, 2 loader, 0 none) and the shadow data at that moment.
  int            m_mode = 0;
  int            m_wait = 0;
  int            own_q[$];
  logic [DW-1:0] exp_q[$];

  always @(negedge CLK) begin : model
    int            e_own;
    logic [DW-1:0] e_dat;
    logic          e_cg, e_lg;
    if (!RST) begin
      chk("rst_cpu_rvalid", CPU_RVALID, 0);
      chk("rst_ld_rvalid", LD_RVALID, 0);
      chk("rst_halted", CPU_HALTED, 0);
      chk("rst_mem_we", MEM_WE, 0);
      m_mode = 0;
      m_wait = 0;
      own_q.delete();
      exp_q.delete();
    end else begin
      e_own = 0;
      e_dat = '0;
      if (own_q.size() > 0) begin
        e_own = own_q.pop_front();
        e_dat = exp_q.pop_front();
      end
      if (m_mode == 0) begin
        if (LD_REQ && m_wait == MAX_WAIT) begin
          e_lg = 1'b1; e_cg = 1'b0;
        end else begin
          e_cg = CPU_REQ; e_lg = LD_REQ && !CPU_REQ;
        end
      end else begin
        e_cg = 1'b0; e_lg = LD_REQ;
      end
      chk("cpu_gnt", CPU_GNT, e_cg);
      chk("ld_gnt", LD_GNT, e_lg);
      chk("halted", CPU_HALTED, m_mode == 2);
      chk("cpu_rvalid", CPU_RVALID, e_own == 1);
      chk("ld_rvalid", LD_RVALID, e_own == 2);
      if (e_own == 1) chk("cpu_rdata", CPU_RDATA, e_dat);
      if (e_own == 2) chk("ld_rdata", LD_RDATA, e_dat);
      chk("mem_we", MEM_WE, e_lg && LD_WE);
      chk("mem_addr", MEM_ADDR, e_lg ? LD_ADDR : CPU_ADDR);
      if (e_lg && LD_WE) chk("mem_wdata", MEM_WDATA, LD_WDATA);
      // advance model
      if (e_lg && LD_WE) sh[LD_ADDR] = LD_WDATA;
      if (e_cg) begin
        own_q.push_back(1); exp_q.push_back(sh[CPU_ADDR]);
      end else if (e_lg && !LD_WE) begin
        own_q.push_back(2); exp_q.push_back(sh[LD_ADDR]);
      end
      else begin
        own_q.push_back(0); exp_q.push_back('0);
      end
      if (m_mode == 0 && LD_REQ && !e_lg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      if (m_mode == 0)      m_mode = LOAD_MODE_REQ ? 1 : 0;
      else if (m_mode == 1) m_mode = LOAD_MODE_REQ ? 2 : 0;
      else                  m_mode = LOAD_MODE_REQ ? 2 : 0;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin : stim
    int lg, cg, we_cnt;
    logic [DW-1:0] old;
    for (int i = 0; i < 1024; i++) sh[i] = DW'($urandom);
    sh[1] = 18'h3A000;
    tick();
    img_load = 1'b0;
    tick();
    tick();

    // reset release, back-to-back CPU fetches
    RST = 1'b1;
    CPU_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      CPU_ADDR = AW'(i);
      @(negedge CLK);
      chk("s1_cpu_gnt", CPU_GNT, 1);
      if (i == 0) chk("s1_first_rvalid", CPU_RVALID, 0);
      else chk("s1_rvalid", CPU_RVALID, 1);
      if (i == 2) chk("s1_data", CPU_RDATA, 18'h3A000);
      tick();
    end

    // starvation relief: one loader grant every MAX_WAIT+1 cycles
    LD_REQ = 1'b1;
    LD_WE = 1'b0;
    lg = 0;
    cg = 0;
    for (int i = 0; i < 20; i++) begin
      CPU_ADDR = AW'($urandom_range(0, 1023));
      LD_ADDR = AW'($urandom_range(0, 1023));
      @(negedge CLK);
      lg += int'(LD_GNT);
      cg += int'(CPU_GNT);
      tick();
    end
    chk("s2_ld_grants", lg, 4);
    chk("s2_cpu_grants", cg, 16);
    LD_REQ = 1'b0;

    // load mode entry with a CPU read outstanding
    CPU_ADDR = 10'h005;
    LOAD_MODE_REQ = 1'b1;
    @(negedge CLK);
    chk("s3_gnt_run", CPU_GNT, 1);
    tick();
    @(negedge CLK);
    chk("s3_drain_rvalid", CPU_RVALID, 1);
    chk("s3_drain_gnt", CPU_GNT, 0);
    chk("s3_drain_halted", CPU_HALTED, 0);
    tick();
    @(negedge CLK);
    chk("s3_halted", CPU_HALTED, 1);
    chk("s3_halted_gnt", CPU_GNT, 0);
    tick();

    // loader write then read-back inside LOAD
    LD_REQ = 1'b1; LD_WE = 1'b1; LD_ADDR = 10'h3FF; LD_WDATA = 18'h15555;
    we_cnt = 0;
    @(negedge CLK);
    chk("s4_wr_gnt", LD_GNT, 1);
    we_cnt += int'(MEM_WE);
    tick();
    LD_WE = 1'b0;
    @(negedge CLK);
    chk("s4_rd_gnt", LD_GNT, 1);
    we_cnt += int'(MEM_WE);
    tick();
    LD_REQ = 1'b0;
    @(negedge CLK);
    chk("s4_ld_rvalid", LD_RVALID, 1);
    chk("s4_ld_rdata", LD_RDATA, 18'h15555);
    we_cnt += int'(MEM_WE);
    chk("s4_we_cycles", we_cnt, 1);
    tick();

    // leave load mode; CPU sees the new word
    LOAD_MODE_REQ = 1'b0;
    CPU_ADDR = 10'h3FF;
    @(negedge CLK);
    chk("s5_still_halted", CPU_HALTED, 1);
    tick();
    @(negedge CLK);
    chk("s5_unhalted", CPU_HALTED, 0);
    chk("s5_gnt", CPU_GNT, 1);
    tick();
    CPU_REQ = 1'b0;
    @(negedge CLK);
    chk("s5_rvalid", CPU_RVALID, 1);
    chk("s5_rdata", CPU_RDATA, 18'h15555);
    tick();

    // reset with a granted read in flight
    CPU_REQ = 1'b1; CPU_ADDR = 10'h007;
    tick();
    RST = 1'b0; CPU_REQ = 1'b0;
    @(negedge CLK);
    chk("s6_rvalid_killed", CPU_RVALID, 0);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("s6_no_late_rvalid", CPU_RVALID, 0);
    tick();
    tick();

    // reset in LOAD coinciding with a loader write: write must not land
    LOAD_MODE_REQ = 1'b1;
    tick();
    tick();
    @(negedge CLK);
    chk("s7_halted", CPU_HALTED, 1);
    old = sh[10'h3FE];
    tick();
    LD_REQ = 1'b1; LD_WE = 1'b1; LD_ADDR = 10'h3FE; LD_WDATA = ~old;
    RST = 1'b0;
    @(negedge CLK);
    chk("s7_we_in_reset", MEM_WE, 0);
    chk("s7_halted_reset", CPU_HALTED, 0);
    tick();
    RST = 1'b1; LD_REQ = 1'b0; LD_WE = 1'b0; LOAD_MODE_REQ = 1'b0;
    CPU_REQ = 1'b1; CPU_ADDR = 10'h3FE;
    @(negedge CLK);
    chk("s7_gnt", CPU_GNT, 1);
    tick();
    CPU_REQ = 1'b0;
    @(negedge CLK);
    chk("s7_old_data", CPU_RDATA, old);
    tick();

    // randomized traffic on a narrow address window to force collisions
    for (int c = 0; c < 3000; c++) begin
      CPU_REQ  = ($urandom_range(0, 3) != 0);
      CPU_ADDR = AW'($urandom_range(0, 15));
      LD_REQ   = ($urandom_range(0, 2) != 0);
      LD_WE    = $urandom_range(0, 1) == 1;
      LD_ADDR  = AW'($urandom_range(0, 15));
      LD_WDATA = DW'($urandom);
      if ($urandom_range(0, 39) == 0) LOAD_MODE_REQ = ~LOAD_MODE_REQ;
      RST = ($urandom_range(0, 299) != 0);
      tick();
    end
    RST = 1'b1;
    CPU_REQ = 1'b0;
    LD_REQ = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
